// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
// Framing FSM states and word-assembly geometry live here.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    RUN    = 3'd4,
    ERROR  = 3'd5
  } loader_state_t;

  function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port between the boot loader and the core.
// Address and data share one width parameter.
interface imem_uart_loader_if #(
  parameter int WIDTH = 32
);
  logic             insMemEn;
  logic [WIDTH-1:0] insMemAddr;
  logic [WIDTH-1:0] insMemDataIn;

  modport master (output insMemEn, output insMemAddr, output insMemDataIn);
  modport slave  (input  insMemEn, input  insMemAddr, input  insMemDataIn);
endinterface

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, glitch-rejecting start detect.
// Emits a one-cycle rxValid or rxFrameErr at the stop-bit sample.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       rxFrameErr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_valid;
  logic             r_ferr;
  logic             w_fall;

  assign w_fall     = r_rx_prev & ~r_rx_sync;
  assign rxByte     = r_shift;
  assign rxValid    = r_valid;
  assign rxFrameErr = r_ferr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          // The edge-detect cycle already counts toward the half-bit delay.
          if (w_fall) begin
            r_state <= RX_START;
            r_cnt   <= CNT_W'(1);
          end
        end
        RX_START: begin
          if (r_cnt == HALF_CNT) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) begin
              r_state <= RX_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_rx_sync) begin
              r_valid <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed image over UART, writes it to
// instruction memory word by word, and releases the core from reset only on a good checksum.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_WORDS    = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx,
  imem_uart_loader_if.master  imem,
  output logic                cpuReset,
  output logic                loadDone,
  output logic                loadError
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);

  logic [7:0]       w_rx_byte;
  logic             w_rx_valid;
  logic             w_rx_ferr;
  logic [15:0]      w_len;

  loader_state_t    r_state;
  logic [7:0]       r_len_lo;
  logic [WC_W-1:0]  r_len;
  logic [1:0]       r_byte_idx;
  logic [WC_W-1:0]  r_word_idx;
  logic [31:0]      r_word;
  logic [7:0]       r_csum;
  logic             r_ins_en;
  logic [WIDTH-1:0] r_ins_addr;
  logic [WIDTH-1:0] r_ins_data;
  logic             r_cpu_rst;
  logic             r_done;
  logic             r_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .rxByte     (w_rx_byte),
    .rxValid    (w_rx_valid),
    .rxFrameErr (w_rx_ferr)
  );

  assign w_len             = {w_rx_byte, r_len_lo};
  assign imem.insMemEn     = r_ins_en;
  assign imem.insMemAddr   = r_ins_addr;
  assign imem.insMemDataIn = r_ins_data;
  assign cpuReset          = r_cpu_rst;
  assign loadDone          = r_done;
  assign loadError         = r_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= LEN_LO;
      r_len_lo   <= '0;
      r_len      <= '0;
      r_byte_idx <= '0;
      r_word_idx <= '0;
      r_word     <= '0;
      r_csum     <= '0;
      r_ins_en   <= 1'b0;
      r_ins_addr <= '0;
      r_ins_data <= '0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ins_en <= 1'b0;
      if (w_rx_ferr && (r_state != RUN)) begin
        r_state <= ERROR;
        r_err   <= 1'b1;
      end else begin
        case (r_state)
          LEN_LO: begin
            if (w_rx_valid) begin
              r_len_lo <= w_rx_byte;
              r_state  <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (w_rx_valid) begin
              r_len <= w_len[WC_W-1:0];
              if (w_len > 16'(MAX_WORDS)) begin
                r_state <= ERROR;
                r_err   <= 1'b1;
              end else if (w_len == 16'd0) begin
                r_state <= CHECK;
              end else begin
                r_state <= DATA;
              end
            end
          end
          DATA: begin
            // Leave only after the final strobe so insMemEn is always seen in DATA.
            if (r_ins_en && (r_word_idx == r_len)) begin
              r_state <= CHECK;
            end else if (w_rx_valid) begin
              r_csum                     <= csum_next(r_csum, w_rx_byte);
              r_word[8*r_byte_idx +: 8]  <= w_rx_byte;
              r_byte_idx                 <= r_byte_idx + 1'b1;
              if (r_byte_idx == LAST_BYTE_IDX) begin
                r_ins_en   <= 1'b1;
                r_ins_addr <= WIDTH'({r_word_idx, 2'b00});
                r_ins_data <= WIDTH'({w_rx_byte, r_word[23:0]});
                r_word_idx <= r_word_idx + 1'b1;
              end
            end
          end
          CHECK: begin
            if (w_rx_valid) begin
              if (w_rx_byte == r_csum) begin
                r_state   <= RUN;
                r_cpu_rst <= 1'b0;
                r_done    <= 1'b1;
              end else begin
                r_state <= ERROR;
                r_err   <= 1'b1;
              end
            end
          end
          RUN: begin
            r_state <= RUN;
          end
          ERROR: begin
            r_state <= ERROR;
          end
          default: begin
            r_state <= ERROR;
            r_err   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader at four clocks per UART bit.
// Each scenario task drives serial frames and compares outputs against hand-computed values.
module tb_imem_uart_loader;

  localparam int CPB = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;
  logic cpuReset;
  logic loadDone;
  logic loadError;

  int check_cnt = 0;
  int err_cnt   = 0;
  int en_count  = 0;
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];

  imem_uart_loader_if #(.WIDTH(32)) imem_bus ();

  imem_uart_loader #(
    .WIDTH        (32),
    .CLKS_PER_BIT (CPB),
    .MAX_WORDS    (128)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .imem      (imem_bus),
    .cpuReset  (cpuReset),
    .loadDone  (loadDone),
    .loadError (loadError)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (imem_bus.insMemEn === 1'b1) begin
      if (en_count < 8) begin
        wr_addr[en_count] = imem_bus.insMemAddr;
        wr_data[en_count] = imem_bus.insMemDataIn;
      end
      en_count = en_count + 1;
      $display("write addr %h data %h", imem_bus.insMemAddr, imem_bus.insMemDataIn);
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clock);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    rx = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    $display("sent byte %h stop %0b", b, stop_bit);
  endtask

  task automatic apply_reset();
    rx = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    en_count = 0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic send_valid_image();
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    check_cnt++; if (imem_bus.insMemEn !== 1'b0) begin err_cnt++; $display("FAIL reset_en: got %b expected 0", imem_bus.insMemEn); end
    check_cnt++; if (imem_bus.insMemAddr !== 32'h0) begin err_cnt++; $display("FAIL reset_addr: got %h expected 0", imem_bus.insMemAddr); end
    check_cnt++; if (imem_bus.insMemDataIn !== 32'h0) begin err_cnt++; $display("FAIL reset_data: got %h expected 0", imem_bus.insMemDataIn); end
    check_cnt++; if (cpuReset !== 1'b1) begin err_cnt++; $display("FAIL reset_cpuReset: got %b expected 1", cpuReset); end
    check_cnt++; if (loadDone !== 1'b0) begin err_cnt++; $display("FAIL reset_loadDone: got %b expected 0", loadDone); end
    check_cnt++; if (loadError !== 1'b0) begin err_cnt++; $display("FAIL reset_loadError: got %b expected 0", loadError); end
  endtask

  task automatic test_valid_image();
    apply_reset();
    send_valid_image();
    check_cnt++; if (cpuReset !== 1'b1) begin err_cnt++; $display("FAIL valid_cpuReset_before_csum: got %b expected 1", cpuReset); end
    send_byte(8'h90, 1'b1);
    check_cnt++; if (en_count !== 2) begin err_cnt++; $display("FAIL valid_count: got %0d expected 2", en_count); end
    check_cnt++; if (wr_addr[0] !== 32'h0) begin err_cnt++; $display("FAIL valid_addr0: got %h expected 00000000", wr_addr[0]); end
    check_cnt++; if (wr_data[0] !== 32'h00000013) begin err_cnt++; $display("FAIL valid_data0: got %h expected 00000013", wr_data[0]); end
    check_cnt++; if (wr_addr[1] !== 32'h4) begin err_cnt++; $display("FAIL valid_addr1: got %h expected 00000004", wr_addr[1]); end
    check_cnt++; if (wr_data[1] !== 32'h00100093) begin err_cnt++; $display("FAIL valid_data1: got %h expected 00100093", wr_data[1]); end
    check_cnt++; if (cpuReset !== 1'b0) begin err_cnt++; $display("FAIL valid_cpuReset: got %b expected 0", cpuReset); end
    check_cnt++; if (loadDone !== 1'b1) begin err_cnt++; $display("FAIL valid_loadDone: got %b expected 1", loadDone); end
    check_cnt++; if (loadError !== 1'b0) begin err_cnt++; $display("FAIL valid_loadError: got %b expected 0", loadError); end
    for (int i = 0; i < 5; i++) send_byte(8'h55, 1'b1);
    send_byte(8'h12, 1'b0);
    check_cnt++; if (en_count !== 2) begin err_cnt++; $display("FAIL run_ignores_rx: got %0d writes expected 2", en_count); end
    check_cnt++; if (loadDone !== 1'b1 || loadError !== 1'b0) begin err_cnt++; $display("FAIL run_sticky: got done %b err %b expected 1 0", loadDone, loadError); end
  endtask

  task automatic test_bad_checksum();
    apply_reset();
    send_valid_image();
    send_byte(8'h91, 1'b1);
    check_cnt++; if (en_count !== 2) begin err_cnt++; $display("FAIL badcs_count: got %0d expected 2", en_count); end
    check_cnt++; if (loadError !== 1'b1) begin err_cnt++; $display("FAIL badcs_loadError: got %b expected 1", loadError); end
    check_cnt++; if (cpuReset !== 1'b1) begin err_cnt++; $display("FAIL badcs_cpuReset: got %b expected 1", cpuReset); end
    check_cnt++; if (loadDone !== 1'b0) begin err_cnt++; $display("FAIL badcs_loadDone: got %b expected 0", loadDone); end
    for (int i = 0; i < 6; i++) send_byte(8'h01, 1'b1);
    check_cnt++; if (en_count !== 2) begin err_cnt++; $display("FAIL badcs_no_more_writes: got %0d expected 2", en_count); end
  endtask

  task automatic test_oversize();
    apply_reset();
    send_byte(8'h81, 1'b1);
    send_byte(8'h00, 1'b1);
    check_cnt++; if (loadError !== 1'b1) begin err_cnt++; $display("FAIL oversize_loadError: got %b expected 1", loadError); end
    check_cnt++; if (cpuReset !== 1'b1) begin err_cnt++; $display("FAIL oversize_cpuReset: got %b expected 1", cpuReset); end
    for (int i = 0; i < 4; i++) send_byte(8'hAA, 1'b1);
    check_cnt++; if (en_count !== 0) begin err_cnt++; $display("FAIL oversize_count: got %0d expected 0", en_count); end
    apply_reset();
    send_byte(8'h80, 1'b1);
    send_byte(8'h00, 1'b1);
    check_cnt++; if (loadError !== 1'b0) begin err_cnt++; $display("FAIL maxlen_accepted: got %b expected 0", loadError); end
  endtask

  task automatic test_empty();
    apply_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    check_cnt++; if (en_count !== 0) begin err_cnt++; $display("FAIL empty_count: got %0d expected 0", en_count); end
    check_cnt++; if (loadDone !== 1'b1) begin err_cnt++; $display("FAIL empty_loadDone: got %b expected 1", loadDone); end
    check_cnt++; if (cpuReset !== 1'b0) begin err_cnt++; $display("FAIL empty_cpuReset: got %b expected 0", cpuReset); end
    apply_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    check_cnt++; if (loadError !== 1'b1) begin err_cnt++; $display("FAIL empty_badcs_loadError: got %b expected 1", loadError); end
    check_cnt++; if (loadDone !== 1'b0) begin err_cnt++; $display("FAIL empty_badcs_loadDone: got %b expected 0", loadDone); end
  endtask

  task automatic test_line_errors();
    apply_reset();
    @(posedge clock); #1; rx = 1'b0;
    @(posedge clock); #1; rx = 1'b1;
    repeat (60) @(posedge clock);
    #1;
    check_cnt++; if (loadError !== 1'b0 || loadDone !== 1'b0) begin err_cnt++; $display("FAIL glitch_state: got done %b err %b expected 0 0", loadDone, loadError); end
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    check_cnt++; if (loadDone !== 1'b1) begin err_cnt++; $display("FAIL glitch_no_byte: got loadDone %b expected 1", loadDone); end
    apply_reset();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1);
    check_cnt++; if (loadError !== 1'b0) begin err_cnt++; $display("FAIL framing_early: got %b expected 0", loadError); end
    send_byte(8'h00, 1'b0);
    check_cnt++; if (loadError !== 1'b1) begin err_cnt++; $display("FAIL framing_loadError: got %b expected 1", loadError); end
    send_byte(8'h00, 1'b1);
    check_cnt++; if (en_count !== 0) begin err_cnt++; $display("FAIL framing_count: got %0d expected 0", en_count); end
    check_cnt++; if (cpuReset !== 1'b1) begin err_cnt++; $display("FAIL framing_cpuReset: got %b expected 1", cpuReset); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1);
    check_cnt++; if (imem_bus.insMemDataIn !== 32'h00000013) begin err_cnt++; $display("FAIL midrst_pre_data: got %h expected 00000013", imem_bus.insMemDataIn); end
    @(posedge clock); #1; rx = 1'b0;
    repeat (CPB + 2) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_cnt++; if (imem_bus.insMemDataIn !== 32'h0) begin err_cnt++; $display("FAIL midrst_data: got %h expected 0", imem_bus.insMemDataIn); end
    check_cnt++; if (imem_bus.insMemAddr !== 32'h0 || imem_bus.insMemEn !== 1'b0) begin err_cnt++; $display("FAIL midrst_addr_en: got %h %b expected 0 0", imem_bus.insMemAddr, imem_bus.insMemEn); end
    check_cnt++; if (cpuReset !== 1'b1 || loadDone !== 1'b0 || loadError !== 1'b0) begin err_cnt++; $display("FAIL midrst_status: got %b%b%b expected 100", cpuReset, loadDone, loadError); end
    apply_reset();
    send_valid_image();
    send_byte(8'h90, 1'b1);
    check_cnt++; if (en_count !== 2) begin err_cnt++; $display("FAIL midrst_reload_count: got %0d expected 2", en_count); end
    check_cnt++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00000013) begin err_cnt++; $display("FAIL midrst_word0: got %h %h expected 00000000 00000013", wr_addr[0], wr_data[0]); end
    check_cnt++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h00100093) begin err_cnt++; $display("FAIL midrst_word1: got %h %h expected 00000004 00100093", wr_addr[1], wr_data[1]); end
    check_cnt++; if (loadDone !== 1'b1 || cpuReset !== 1'b0) begin err_cnt++; $display("FAIL midrst_done: got done %b cpuReset %b expected 1 0", loadDone, cpuReset); end
  endtask

  initial begin
    test_reset();
    test_valid_image();
    test_bad_checksum();
    test_oversize();
    test_empty();
    test_line_errors();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
